// File: rtl/cdb_arbiter.sv
// Completion-slot arbiter: reserves CDB slots for fixed-latency FUs at issue, fills the rest with variable-latency FUs round-robin.
// Latency: issue grant is combinational and its slot is used the next cycle; variable grants are combinational from valid.
// Backpressure: a variable FU without a slot keeps its valid high; the starvation counter caps new fixed issue to free a slot.
module cdb_arbiter #(
  parameter int N             = 2,
  parameter int NUM_FU_ALU    = 3,
  parameter int NUM_FU_MULT   = 2,
  parameter int NUM_FU_BRANCH = 1,
  parameter int NUM_FU_LDST   = 1,
  parameter int NUM_FU_TOTAL  = NUM_FU_LDST + NUM_FU_MULT + NUM_FU_ALU + NUM_FU_BRANCH,
  parameter int STARVE_LIMIT  = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_FU_ALU-1:0]               alu_issue_req_i,
  input  logic [NUM_FU_BRANCH-1:0]            branch_issue_req_i,
  output logic [NUM_FU_ALU-1:0]               alu_issue_gnt_o,
  output logic [NUM_FU_BRANCH-1:0]            branch_issue_gnt_o,
  input  logic [NUM_FU_MULT-1:0]              mult_cdb_valid_i,
  input  logic [NUM_FU_LDST-1:0]              ldst_cdb_valid_i,
  output logic [NUM_FU_MULT-1:0]              mult_cdb_en_o,
  output logic [NUM_FU_LDST-1:0]              ldst_cdb_en_o,
  output logic [N-1:0][NUM_FU_TOTAL-1:0]      complete_gnt_bus_o,
  output logic                                starve_reserve_o
);

  // Variable set V occupies the low FU bits (ldst, then mult); fixed FUs sit above it.
  localparam int NV  = NUM_FU_LDST + NUM_FU_MULT;
  localparam int NF  = NUM_FU_ALU + NUM_FU_BRANCH;
  localparam int RRW = (NV > 1) ? $clog2(NV) : 1;
  localparam int WCW = $clog2(STARVE_LIMIT + 2);

  // Fixed reservations use local bit order {branch, alu}, i.e. global bit NV + b.
  logic [NF-1:0]                  fixed_q, fixed_d;
  logic [RRW-1:0]                 rr_q, rr_d;
  logic [WCW-1:0]                 wait_q, wait_d;

  logic [NV-1:0]                  var_vld;
  logic [NV-1:0]                  var_gnt;
  logic [NUM_FU_ALU-1:0]          alu_gnt;
  logic [NUM_FU_BRANCH-1:0]       br_gnt;
  logic [N-1:0][NUM_FU_TOTAL-1:0] gnt_bus;
  logic                           starve;
  int                             issue_cnt;
  int                             issue_cap;
  int                             slot;
  int                             idx;

  assign var_vld = {mult_cdb_valid_i, ldst_cdb_valid_i};
  assign starve  = (wait_q >= WCW'(STARVE_LIMIT));

  // Issue grant: branch first then ALU, lowest index first, capped so a starved variable FU gets a slot next cycle.
  always_comb begin
    alu_gnt   = '0;
    br_gnt    = '0;
    issue_cnt = 0;
    issue_cap = starve ? (N - 1) : N;
    for (int i = 0; i < NUM_FU_BRANCH; i++) begin
      if (branch_issue_req_i[i] && (issue_cnt < issue_cap)) begin
        br_gnt[i] = 1'b1;
        issue_cnt = issue_cnt + 1;
      end
    end
    for (int i = 0; i < NUM_FU_ALU; i++) begin
      if (alu_issue_req_i[i] && (issue_cnt < issue_cap)) begin
        alu_gnt[i] = 1'b1;
        issue_cnt  = issue_cnt + 1;
      end
    end
    fixed_d = {br_gnt, alu_gnt};
  end

  // Slot fill: last cycle's reservations first (descending FU bit), then valid variable FUs scanned from rr_q with wrap.
  always_comb begin
    gnt_bus = '0;
    var_gnt = '0;
    rr_d    = rr_q;
    slot    = 0;
    idx     = 0;
    for (int b = NF - 1; b >= 0; b--) begin
      if (fixed_q[b] && (slot < N)) begin
        for (int k = 0; k < N; k++) begin
          if (slot == k) gnt_bus[k][NV+b] = 1'b1;
        end
        slot = slot + 1;
      end
    end
    for (int j = 0; j < NV; j++) begin
      idx = int'(rr_q) + j;
      if (idx >= NV) idx = idx - NV;
      for (int v = 0; v < NV; v++) begin
        if ((idx == v) && var_vld[v] && (slot < N)) begin
          for (int k = 0; k < N; k++) begin
            if (slot == k) gnt_bus[k][v] = 1'b1;
          end
          var_gnt[v] = 1'b1;
          rr_d       = (v == NV - 1) ? '0 : RRW'(v + 1);
          slot       = slot + 1;
        end
      end
    end
  end

  // Starvation counter: counts cycles where some variable FU is valid but none was granted, saturating.
  always_comb begin
    wait_d = wait_q;
    if ((|var_gnt) || !(|var_vld)) begin
      wait_d = '0;
    end else if (wait_q < WCW'(STARVE_LIMIT + 1)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // State registers; reset drops any pending reservation.
  always_ff @(posedge clock) begin
    if (reset) begin
      fixed_q <= '0;
      rr_q    <= '0;
      wait_q  <= '0;
    end else begin
      fixed_q <= fixed_d;
      rr_q    <= rr_d;
      wait_q  <= wait_d;
    end
  end

  assign alu_issue_gnt_o    = reset ? '0 : alu_gnt;
  assign branch_issue_gnt_o = reset ? '0 : br_gnt;
  assign complete_gnt_bus_o = reset ? '0 : gnt_bus;
  assign ldst_cdb_en_o      = reset ? '0 : var_gnt[NUM_FU_LDST-1:0];
  assign mult_cdb_en_o      = reset ? '0 : var_gnt[NV-1:NUM_FU_LDST];
  assign starve_reserve_o   = reset ? 1'b0 : starve;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
// Bus values are compared as {slot1, slot0}, 7 bits each.
// FU bits: 0 ldst, 1-2 mult, 3-5 alu, 6 branch.
module tb_cdb_arbiter;

  logic              clock = 1'b0;
  logic              reset;
  logic [2:0]        alu_req;
  logic [0:0]        br_req;
  logic [2:0]        alu_gnt;
  logic [0:0]        br_gnt;
  logic [1:0]        mult_vld;
  logic [0:0]        ldst_vld;
  logic [1:0]        mult_en;
  logic [0:0]        ldst_en;
  logic [1:0][6:0]   bus;
  logic              starve;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cdb_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .alu_issue_req_i    (alu_req),
    .branch_issue_req_i (br_req),
    .alu_issue_gnt_o    (alu_gnt),
    .branch_issue_gnt_o (br_gnt),
    .mult_cdb_valid_i   (mult_vld),
    .ldst_cdb_valid_i   (ldst_vld),
    .mult_cdb_en_o      (mult_en),
    .ldst_cdb_en_o      (ldst_en),
    .complete_gnt_bus_o (bus),
    .starve_reserve_o   (starve)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic [2:0] a, input logic b, input logic [1:0] m, input logic l);
    alu_req  = a;
    br_req   = b;
    mult_vld = m;
    ldst_vld = l;
    #1;
  endtask

  function automatic logic [31:0] all_out();
    return 32'({bus, alu_gnt, br_gnt, mult_en, ldst_en, starve});
  endfunction

  initial begin
    reset = 1'b1;
    drive(3'b000, 1'b0, 2'b00, 1'b0);
    next_cycle();
    // Outputs forced low while reset is high, even with every request/valid raised.
    drive(3'b111, 1'b1, 2'b11, 1'b1);
    chk("in_reset_all_zero", all_out(), 32'h0);
    next_cycle();
    reset = 1'b0;
    drive(3'b000, 1'b0, 2'b00, 1'b0);
    chk("idle0", all_out(), 32'h0);
    next_cycle();
    chk("idle1", all_out(), 32'h0);
    next_cycle();
    chk("idle2", all_out(), 32'h0);

    // Branch beats ALUs; cap of 2 grants.
    next_cycle();
    drive(3'b111, 1'b1, 2'b00, 1'b0);
    chk("fix_br_gnt", 32'(br_gnt), 32'h1);
    chk("fix_alu_gnt", 32'(alu_gnt), 32'h1);
    chk("fix_bus_t0", 32'(bus), 32'h0);
    next_cycle();
    drive(3'b000, 1'b0, 2'b00, 1'b0);
    chk("fix_bus_t1", 32'(bus), 32'({7'b0001000, 7'b1000000}));
    chk("fix_alu_gnt_t1", 32'(alu_gnt), 32'h0);

    // Round robin across ldst, mult0, mult1 with all valid.
    next_cycle();
    drive(3'b000, 1'b0, 2'b11, 1'b1);
    chk("rr_bus_t0", 32'(bus), 32'({7'b0000010, 7'b0000001}));
    chk("rr_en_t0", 32'({mult_en, ldst_en}), 32'b011);
    next_cycle();
    chk("rr_bus_t1", 32'(bus), 32'({7'b0000001, 7'b0000100}));
    chk("rr_en_t1", 32'({mult_en, ldst_en}), 32'b101);
    next_cycle();
    chk("rr_bus_t2", 32'(bus), 32'({7'b0000100, 7'b0000010}));
    chk("rr_en_t2", 32'({mult_en, ldst_en}), 32'b110);
    next_cycle();
    drive(3'b000, 1'b0, 2'b00, 1'b0);
    chk("rr_idle_bus", 32'(bus), 32'h0);

    // Starvation: ALUs hog both slots until the counter caps issue.
    next_cycle();
    drive(3'b111, 1'b0, 2'b00, 1'b0);
    chk("stv_t0_alu_gnt", 32'(alu_gnt), 32'b011);
    chk("stv_t0_starve", 32'(starve), 32'h0);
    next_cycle();
    drive(3'b111, 1'b0, 2'b01, 1'b0);
    chk("stv_t1_bus", 32'(bus), 32'({7'b0001000, 7'b0010000}));
    chk("stv_t1_men", 32'(mult_en), 32'b00);
    chk("stv_t1_starve", 32'(starve), 32'h0);
    next_cycle();
    chk("stv_t2_bus", 32'(bus), 32'({7'b0001000, 7'b0010000}));
    chk("stv_t2_men", 32'(mult_en), 32'b00);
    chk("stv_t2_starve", 32'(starve), 32'h0);
    next_cycle();
    chk("stv_t3_starve", 32'(starve), 32'h1);
    chk("stv_t3_alu_gnt", 32'(alu_gnt), 32'b001);
    chk("stv_t3_men", 32'(mult_en), 32'b00);
    next_cycle();
    chk("stv_t4_men", 32'(mult_en), 32'b01);
    chk("stv_t4_bus", 32'(bus), 32'({7'b0000010, 7'b0001000}));
    chk("stv_t4_starve", 32'(starve), 32'h1);
    next_cycle();
    drive(3'b000, 1'b0, 2'b00, 1'b0);
    chk("stv_t5_starve", 32'(starve), 32'h0);
    chk("stv_t5_bus", 32'(bus), 32'({7'b0000000, 7'b0001000}));

    // Reset mid-operation drops the pending reservation and restarts round robin at ldst.
    next_cycle();
    drive(3'b011, 1'b0, 2'b00, 1'b0);
    chk("rst_t0_alu_gnt", 32'(alu_gnt), 32'b011);
    next_cycle();
    reset = 1'b1;
    drive(3'b111, 1'b1, 2'b11, 1'b1);
    chk("rst_t1_bus", 32'(bus), 32'h0);
    chk("rst_t1_all", all_out(), 32'h0);
    next_cycle();
    reset = 1'b0;
    drive(3'b011, 1'b0, 2'b11, 1'b1);
    chk("rst_t2_bus", 32'(bus), 32'({7'b0000010, 7'b0000001}));
    chk("rst_t2_alu_gnt", 32'(alu_gnt), 32'b011);

    // Ldst valid collides with two reserved ALUs, then wins the next cycle.
    next_cycle();
    drive(3'b000, 1'b0, 2'b00, 1'b1);
    chk("hold_ldst_en", 32'(ldst_en), 32'h0);
    chk("hold_bus", 32'(bus), 32'({7'b0001000, 7'b0010000}));
    next_cycle();
    chk("free_ldst_en", 32'(ldst_en), 32'h1);
    chk("free_bus", 32'(bus), 32'({7'b0000000, 7'b0000001}));
    next_cycle();
    drive(3'b000, 1'b0, 2'b00, 1'b0);
    chk("end_idle", all_out(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
